quad_encoder_bank: RTL and testbench

//  Parametrised N-channel quadrature encoder front end for the drive base; replaces the

---
 rtl/enc_pkg.sv | 60 ++++++
 rtl/quad_channel.sv | 119 +++++++++++
 rtl/quad_encoder_bank.sv | 81 ++++++++
 tb/tb_quad_encoder_bank.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared quadrature decoding types and helpers for the encoder bank.
// Phase order (as {A,B}) 00 -> 10 -> 11 -> 01 -> 00 is the forward direction.
package enc_pkg;

    typedef logic signed [1:0] step_t;

    localparam logic [1:0] QS_00 = 2'b00;
    localparam logic [1:0] QS_10 = 2'b10;
    localparam logic [1:0] QS_11 = 2'b11;
    localparam logic [1:0] QS_01 = 2'b01;

    localparam step_t STEP_NONE = 2'sb00;
    localparam step_t STEP_FWD  = 2'sb01;
    localparam step_t STEP_REV  = 2'sb11;

    typedef struct packed {
        step_t step;
        logic  illegal;
    } dec_t;

    function automatic logic [1:0] phase_index(input logic [1:0] ab);
        case (ab)
            QS_00:   phase_index = 2'd0;
            QS_10:   phase_index = 2'd1;
            QS_11:   phase_index = 2'd2;
            QS_01:   phase_index = 2'd3;
            default: phase_index = 2'd0;
        endcase
    endfunction

    // Position difference around the 4-phase ring; a half-turn means both pins moved.
    function automatic dec_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] diff;
        diff = phase_index(cur) - phase_index(prev);
        decode_step.step    = STEP_NONE;
        decode_step.illegal = 1'b0;
        case (diff)
            2'd1:    decode_step.step    = STEP_FWD;
            2'd3:    decode_step.step    = STEP_REV;
            2'd2:    decode_step.illegal = 1'b1;
            default: decode_step.step    = STEP_NONE;
        endcase
    endfunction

    function automatic logic signed [31:0] sat_vel(input logic signed [31:0] val,
                                                   input int unsigned width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 32'd1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 32'd1));
        if (val > hi) begin
            sat_vel = hi;
        end else if (val < lo) begin
            sat_vel = lo;
        end else begin
            sat_vel = val;
        end
    endfunction

endpackage

// File: rtl/quad_channel.sv
// One encoder channel: synchroniser, glitch filter, priming, x4 decode,
// wrapping position count, windowed velocity delta and sticky error flag.
module quad_channel
    import enc_pkg::*;
#(
    parameter int COUNT_W  = 32,
    parameter int FILT_LEN = 3,
    parameter int VEL_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               a,
    input  logic               b,
    input  logic               clear,
    input  logic               err_clear,
    input  logic               win_end,
    output logic [COUNT_W-1:0] count,
    output logic [VEL_W-1:0]   vel,
    output logic               err
);

    // Two synchroniser stages followed by FILT_LEN filter samples.
    localparam int PIPE_LEN = 2 + FILT_LEN;
    localparam int DELTA_W  = VEL_W + 1;

    logic [1:0]                pipe_r [PIPE_LEN];
    logic [PIPE_LEN-1:0]       vld_r;
    logic [1:0]                filt_r;
    logic                      primed_r;
    logic [COUNT_W-1:0]        count_r;
    logic signed [DELTA_W-1:0] delta_r;
    logic [VEL_W-1:0]          vel_r;
    logic                      err_r;

    logic                      stable_s;
    logic                      accept_s;
    dec_t                      dec_s;
    step_t                     step_s;
    logic                      illegal_s;
    logic signed [31:0]        delta_sum_s;

    // Synchroniser/filter shift chain; vld_r keeps reset-value samples out of the filter.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE_LEN; i++) begin
                pipe_r[i] <= 2'b00;
            end
            vld_r <= '0;
        end else begin
            pipe_r[0] <= {a, b};
            for (int i = 1; i < PIPE_LEN; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
            vld_r <= {vld_r[PIPE_LEN-2:0], 1'b1};
        end
    end

    // Filter acceptance and step decode against the current filtered state.
    always_comb begin
        stable_s = vld_r[PIPE_LEN-1];
        for (int i = 3; i < PIPE_LEN; i++) begin
            stable_s = stable_s & (pipe_r[i] == pipe_r[2]);
        end
        accept_s    = stable_s & (~primed_r | (pipe_r[2] != filt_r));
        dec_s       = decode_step(filt_r, pipe_r[2]);
        step_s      = STEP_NONE;
        illegal_s   = 1'b0;
        if (accept_s && primed_r) begin
            step_s    = dec_s.step;
            illegal_s = dec_s.illegal;
        end else begin
            step_s    = STEP_NONE;
            illegal_s = 1'b0;
        end
        delta_sum_s = 32'(delta_r) + 32'(step_s);
    end

    // Filtered state, position, velocity window accumulation and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_r   <= 2'b00;
            primed_r <= 1'b0;
            count_r  <= '0;
            delta_r  <= '0;
            vel_r    <= '0;
            err_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                filt_r   <= pipe_r[2];
                primed_r <= 1'b1;
            end
            if (clear) begin
                count_r <= '0;
            end else begin
                case (step_s)
                    STEP_FWD: count_r <= count_r + COUNT_W'(1);
                    STEP_REV: count_r <= count_r - COUNT_W'(1);
                    default:  count_r <= count_r;
                endcase
            end
            if (win_end) begin
                vel_r   <= VEL_W'(sat_vel(delta_sum_s, VEL_W));
                delta_r <= '0;
            end else begin
                delta_r <= DELTA_W'(sat_vel(delta_sum_s, DELTA_W));
            end
            if (illegal_s) begin
                err_r <= 1'b1;
            end else if (err_clear) begin
                err_r <= 1'b0;
            end
        end
    end

    assign count = count_r;
    assign vel   = vel_r;
    assign err   = err_r;

endmodule

// File: rtl/quad_encoder_bank.sv
// N-channel quadrature encoder front end: per-channel decoders plus the shared
// velocity window counter and the all-channel position snapshot.
module quad_encoder_bank
    import enc_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int COUNT_W    = 32,
    parameter int FILT_LEN   = 3,
    parameter int VEL_WINDOW = 50000,
    parameter int VEL_W      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         enc_a,
    input  logic [NUM_CH-1:0]         enc_b,
    input  logic [NUM_CH-1:0]         clear,
    input  logic                      snapshot,
    input  logic [NUM_CH-1:0]         err_clear,
    output logic [NUM_CH*COUNT_W-1:0] count_flat,
    output logic [NUM_CH*COUNT_W-1:0] snap_flat,
    output logic [NUM_CH*VEL_W-1:0]   vel_flat,
    output logic                      vel_valid,
    output logic [NUM_CH-1:0]         err
);

    localparam int WIN_W = (VEL_WINDOW > 2) ? $clog2(VEL_WINDOW) : 1;

    logic [WIN_W-1:0]          win_r;
    logic                      win_end_s;
    logic                      vel_valid_r;
    logic [NUM_CH*COUNT_W-1:0] snap_r;

    assign win_end_s = (win_r == WIN_W'(VEL_WINDOW - 1));

    // Free-running window counter; vel_valid follows the terminal edge by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_r       <= '0;
            vel_valid_r <= 1'b0;
        end else begin
            vel_valid_r <= win_end_s;
            if (win_end_s) begin
                win_r <= '0;
            end else begin
                win_r <= win_r + WIN_W'(1);
            end
        end
    end

    // Snapshot takes the registered counts as seen this cycle, before any clear or step.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_r <= '0;
        end else if (snapshot) begin
            snap_r <= count_flat;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        quad_channel #(
            .COUNT_W  (COUNT_W),
            .FILT_LEN (FILT_LEN),
            .VEL_W    (VEL_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .a         (enc_a[ch]),
            .b         (enc_b[ch]),
            .clear     (clear[ch]),
            .err_clear (err_clear[ch]),
            .win_end   (win_end_s),
            .count     (count_flat[ch*COUNT_W +: COUNT_W]),
            .vel       (vel_flat[ch*VEL_W +: VEL_W]),
            .err       (err[ch])
        );
    end

    assign snap_flat = snap_r;
    assign vel_valid = vel_valid_r;

endmodule

// File: tb/tb_quad_encoder_bank.sv
// Directed bench for quad_encoder_bank: a 2-channel FILT_LEN=3 instance for
// counting/filter/snapshot, and a 1-channel short-window instance for velocity.
module tb_quad_encoder_bank;

    logic        clk;
    logic        reset;
    logic [1:0]  enc_a, enc_b, clear, err_clear;
    logic        snapshot;
    logic [63:0] count_flat, snap_flat;
    logic [31:0] vel_flat;
    logic        vel_valid;
    logic [1:0]  err;

    logic        a2, b2, clear2, snap2, errc2;
    logic [7:0]  count2, snapo2;
    logic [3:0]  vel2;
    logic        vv2;
    logic        err2;

    int total = 0;
    int bad   = 0;

    logic [1:0] fwd_from11 [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
    logic [1:0] fwd_from00 [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] rev_from00 [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [3:0] vq [$];
    logic       prev_vv;

    quad_encoder_bank #(
        .NUM_CH(2), .COUNT_W(32), .FILT_LEN(3), .VEL_WINDOW(50000), .VEL_W(16)
    ) dut (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
        .snapshot(snapshot), .err_clear(err_clear), .count_flat(count_flat),
        .snap_flat(snap_flat), .vel_flat(vel_flat), .vel_valid(vel_valid), .err(err)
    );

    quad_encoder_bank #(
        .NUM_CH(1), .COUNT_W(8), .FILT_LEN(1), .VEL_WINDOW(16), .VEL_W(4)
    ) dut_vel (
        .clk(clk), .reset(reset), .enc_a(a2), .enc_b(b2), .clear(clear2),
        .snapshot(snap2), .err_clear(errc2), .count_flat(count2),
        .snap_flat(snapo2), .vel_flat(vel2), .vel_valid(vv2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drives one channel-2 phase per cycle and records every velocity update.
    task automatic run_vel(input logic [1:0] seq [4], input int n, input logic move);
        vq.delete();
        prev_vv = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (move) {a2, b2} = seq[i % 4];
            tick(1);
            if (prev_vv) chk("vv_one_cycle", 64'(vv2), 64'h0);
            if (vv2) vq.push_back(vel2);
            prev_vv = vv2;
        end
    endtask

    initial begin
        reset = 1'b1; enc_a = 2'b11; enc_b = 2'b11; clear = 2'b00; err_clear = 2'b00;
        snapshot = 1'b0; a2 = 1'b0; b2 = 1'b0; clear2 = 1'b0; snap2 = 1'b0; errc2 = 1'b0;
        tick(3);
        chk("rst_count", count_flat, 64'h0);
        chk("rst_snap", snap_flat, 64'h0);
        chk("rst_vel", 64'(vel_flat), 64'h0);
        chk("rst_vel_valid", 64'(vel_valid), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        reset = 1'b0;
        tick(12);
        chk("prime_count", count_flat, 64'h0);
        chk("prime_err", 64'(err), 64'h0);

        // Forward steps on ch0, update exactly five edges after the sampling edge.
        for (int k = 0; k < 8; k++) begin
            {enc_a[0], enc_b[0]} = fwd_from11[k % 4];
            tick(5);
            chk("lat_hold", 64'(count_flat[31:0]), 64'(k));
            tick(1);
            chk("lat_upd", 64'(count_flat[31:0]), 64'(k + 1));
            tick(4);
        end
        chk("fwd8_ch0", 64'(count_flat[31:0]), 64'd8);
        chk("fwd8_ch1", 64'(count_flat[63:32]), 64'd0);

        enc_a[0] = 1'b0;
        tick(2);
        enc_a[0] = 1'b1;
        tick(10);
        chk("glitch_count", 64'(count_flat[31:0]), 64'd8);
        chk("glitch_err", 64'(err), 64'h0);

        {enc_a[0], enc_b[0]} = 2'b00;
        tick(8);
        chk("illegal_err", 64'(err), 64'h1);
        chk("illegal_count", 64'(count_flat[31:0]), 64'd8);
        err_clear = 2'b01;
        tick(1);
        err_clear = 2'b00;
        chk("err_clear", 64'(err), 64'h0);

        {enc_a[1], enc_b[1]} = 2'b10;
        tick(8);
        chk("rev_wrap", 64'(count_flat[63:32]), 64'hFFFF_FFFF);
        {enc_a[1], enc_b[1]} = 2'b11;
        tick(8);
        chk("fwd_wrap", 64'(count_flat[63:32]), 64'h0);
        {enc_a[1], enc_b[1]} = 2'b10;
        tick(8);

        for (int k = 0; k < 92; k++) begin
            {enc_a[0], enc_b[0]} = fwd_from00[k % 4];
            tick(4);
        end
        tick(8);
        chk("count100", 64'(count_flat[31:0]), 64'd100);
        snapshot = 1'b1;
        clear = 2'b01;
        tick(1);
        snapshot = 1'b0;
        clear = 2'b00;
        chk("snap_ch0", 64'(snap_flat[31:0]), 64'd100);
        chk("snap_ch1", 64'(snap_flat[63:32]), 64'hFFFF_FFFF);
        chk("clear_ch0", 64'(count_flat[31:0]), 64'd0);
        chk("keep_ch1", 64'(count_flat[63:32]), 64'hFFFF_FFFF);
        chk("err_quiet", 64'(err), 64'h0);

        // Velocity instance: a step every cycle saturates both directions.
        run_vel(fwd_from00, 48, 1'b1);
        tick(4);
        chk("vel_fwd_n", 64'(vq.size() >= 2), 64'h1);
        chk("vel_fwd_sat", 64'(vq[1]), 64'h7);
        chk("cnt2_fwd", 64'(count2), 64'd48);
        run_vel(rev_from00, 48, 1'b1);
        tick(4);
        chk("vel_rev_n", 64'(vq.size() >= 2), 64'h1);
        chk("vel_rev_sat", 64'(vq[1]), 64'h8);
        chk("cnt2_rev", 64'(count2), 64'd0);
        run_vel(rev_from00, 48, 1'b0);
        chk("vel_idle_n", 64'(vq.size() >= 3), 64'h1);
        chk("vel_idle", 64'(vq[2]), 64'h0);
        chk("err2_quiet", 64'(err2), 64'h0);

        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("midrst_count", count_flat, 64'h0);
        chk("midrst_snap", snap_flat, 64'h0);
        chk("midrst_count2", 64'(count2), 64'h0);
        chk("midrst_vv2", 64'(vv2), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
